// File: rtl/branch_predictor_btb_if.sv
// Branch predictor bundle: IF-stage lookup, EX-stage resolve/correct, perf counters.
// The pipeline side drives the master modport and the BTB drives the slave modport.
interface branch_predictor_btb_if #(
    parameter int ADDR_W = 32
);
    // IF-stage lookup
    logic [ADDR_W-1:0] if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    // EX-stage resolution
    logic              ex_valid;
    logic              ex_stall;
    logic              ex_is_branch;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;

    logic [31:0]       branch_cnt;
    logic [31:0]       mispredict_cnt;

    modport master (
        output if_pc,
        output ex_valid, ex_stall, ex_is_branch, ex_pc, ex_taken, ex_target,
        output ex_pred_taken, ex_pred_target,
        input  pred_hit, pred_taken, pred_target,
        input  mispredict, redirect_pc,
        input  branch_cnt, mispredict_cnt
    );

    modport slave (
        input  if_pc,
        input  ex_valid, ex_stall, ex_is_branch, ex_pc, ex_taken, ex_target,
        input  ex_pred_taken, ex_pred_target,
        output pred_hit, pred_taken, pred_target,
        output mispredict, redirect_pc,
        output branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Flop-based BTB with saturating counters; perf counters under BTB_PERF_CNT_EN.
// Latency: lookup and mispredict are combinational; table updates land on the next clk edge.
// Backpressure: ex_stall suppresses table/counter updates but never masks mispredict.
module branch_predictor_btb #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_predictor_btb_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    // Entry storage
    logic              ent_vld [ENTRIES];
    logic [TAG_W-1:0]  ent_tag [ENTRIES];
    logic [ADDR_W-1:0] ent_tgt [ENTRIES];
    logic [CNT_W-1:0]  ent_cnt [ENTRIES];

    // IF-stage lookup
    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic              if_hit;
    logic              if_taken;
    logic [ADDR_W-1:0] if_pc_plus4;

    assign if_idx      = bp.if_pc[IDX_W+1:2];
    assign if_tag      = bp.if_pc[ADDR_W-1:IDX_W+2];
    assign if_pc_plus4 = bp.if_pc + PC_STEP;

    // Reads current flop contents only, so a same-cycle update is not visible here.
    assign if_hit   = ent_vld[if_idx] && (ent_tag[if_idx] == if_tag);
    assign if_taken = if_hit && ent_cnt[if_idx][CNT_W-1];

    assign bp.pred_hit    = if_hit;
    assign bp.pred_taken  = if_taken;
    assign bp.pred_target = if_taken ? ent_tgt[if_idx] : if_pc_plus4;

    // EX-stage resolution
    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              ex_hit;
    logic              ex_branch;
    logic              upd;
    logic              dir_wrong;
    logic              tgt_wrong;
    logic              mispredict;
    logic [ADDR_W-1:0] ex_pc_plus4;
    logic [CNT_W-1:0]  cnt_cur;

    assign ex_idx      = bp.ex_pc[IDX_W+1:2];
    assign ex_tag      = bp.ex_pc[ADDR_W-1:IDX_W+2];
    assign ex_hit      = ent_vld[ex_idx] && (ent_tag[ex_idx] == ex_tag);
    assign cnt_cur     = ent_cnt[ex_idx];
    assign ex_pc_plus4 = bp.ex_pc + PC_STEP;

    assign ex_branch = bp.ex_valid && bp.ex_is_branch;
    assign upd       = ex_branch && !bp.ex_stall;

    assign dir_wrong  = bp.ex_taken != bp.ex_pred_taken;
    assign tgt_wrong  = bp.ex_taken && bp.ex_pred_taken
                        && (bp.ex_target != bp.ex_pred_target);
    // Flush wins over stall in the pipeline, so ex_stall is deliberately absent here.
    assign mispredict = ex_branch && (dir_wrong || tgt_wrong);

    assign bp.mispredict  = mispredict;
    assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : ex_pc_plus4;

    // Table update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_vld[i] <= 1'b0;
                ent_tag[i] <= '0;
                ent_tgt[i] <= '0;
                ent_cnt[i] <= '0;
            end
        end else if (upd) begin
            if (ex_hit) begin
                if (bp.ex_taken) begin
                    ent_tgt[ex_idx] <= bp.ex_target;
                    if (cnt_cur != CNT_MAX) begin
                        ent_cnt[ex_idx] <= cnt_cur + CNT_W'(1);
                    end
                end else if (cnt_cur != CNT_ZERO) begin
                    ent_cnt[ex_idx] <= cnt_cur - CNT_W'(1);
                end
            end else if (bp.ex_taken) begin
                // Allocation evicts whatever aliased entry lived at this index.
                ent_vld[ex_idx] <= 1'b1;
                ent_tag[ex_idx] <= ex_tag;
                ent_tgt[ex_idx] <= bp.ex_target;
                ent_cnt[ex_idx] <= CNT_WEAK;
            end
        end
    end

`ifdef BTB_PERF_CNT_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (upd) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredict) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign bp.branch_cnt     = branch_cnt_q;
    assign bp.mispredict_cnt = mispredict_cnt_q;
`else
    assign bp.branch_cnt     = 32'd0;
    assign bp.mispredict_cnt = 32'd0;
`endif

endmodule
